logicnets_input_quantizer: RTL and testbench
============================================

// Module: logicnets_input_quantizer
// PURPOSE
//  Upstream stage of the layer-0 LUT neurons. Accepts raw signed features one per beat on valid/ready,
//  quantizes each to a BITS-wide unsigned code, and packs N_FEAT codes into one frame vector.
//  The frame vector drives the layer-0 neuron fan-in bits.
//  Output is a registered, stable vector with its own valid/ready handshake.
// PARAMETERS
//  N_FEAT  4   features per frame (>=2)
//  IN_W    16  signed input feature width
//  BITS    2   quantized code width per feature (1..4)
//  SHIFT   4   arithmetic right shift applied to the input (scale)
//  OFFSET  2   signed offset added after the shift (zero-point)
// PORTS
//  clk      in   1             single clock, rising edge
//  rst_n    in   1             asynchronous active-low reset
//  s_valid  in   1             input feature valid
//  s_ready  out  1             stage can accept a feature
//  s_data   in   IN_W          signed feature value
//  m_valid  out  1             packed frame valid
//  m_ready  in   1             downstream layer accepts the frame
//  m_data   out  N_FEAT*BITS   packed codes; feature i occupies [i*BITS +: BITS]
//  s_last   in   1             (FRAME_ERR_EN only) marks the last feature of a frame
//  err      out  1             (FRAME_ERR_EN only) sticky framing error
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=COLLECT, cnt=0, m_valid=0, m_data=0, err=0; s_ready=1 after release.
//  - Quantize: q = (s_data >>> SHIFT) + OFFSET, computed at IN_W+1 bits signed.
//    Clamp q to [0, 2^BITS-1]. Purely combinational.
//  - COLLECT: s_ready=1, m_valid=0. A beat is accepted when s_valid&s_ready.
//    On accept, write code to slot cnt and increment cnt.
//    Accepting slot N_FEAT-1 moves the FSM to FULL and sets cnt=0.
//  - FULL: s_ready=0, m_valid=1, m_data held stable.
//    On m_ready=1, return to COLLECT and drop m_valid in the same edge.
//  - Latency: m_valid rises the cycle after the last feature is accepted.
//    Minimum frame period is N_FEAT+1 cycles (no overlap; s_ready is low throughout FULL).
//  - m_ready while in COLLECT is ignored. s_valid while in FULL is not accepted; the source holds its data.
//  - Slots not yet written in a new frame keep the previous values.
//    m_data is observed only while m_valid=1, and all slots are rewritten by then.
//  - A reset mid-frame discards the partial frame. No output glitch: m_valid is already 0 in COLLECT.
// CONFIGURATION
//  - LOGICNETS_FRAME_ERR_EN defined: adds the s_last and err ports and a DROP state.
//    - s_last=1 on an accepted beat with cnt<N_FEAT-1 (early last): set err.
//      Discard the partial frame, cnt=0, stay in COLLECT.
//    - s_last=0 on the beat filling slot N_FEAT-1 (missing last): the frame is still emitted and err is set.
//      After the frame handshake, go to DROP instead of COLLECT.
//    - DROP: s_ready=1. Accepted beats are discarded until one with s_last=1 is accepted.
//      That beat is also discarded; then return to COLLECT.
//    - err is sticky and clears only on reset.
//  - Macro undefined: no s_last or err ports, no DROP state. Framing is implied purely by the beat count.
// STRUCTURE
//  - logicnets_pkg holds:
//    - typedef enum {COLLECT, FULL, DROP} lnq_state_t
//    - localparam function for cnt width ($clog2(N_FEAT))
//    - quantizer clamp helper constants
//  - Sub-module logicnets_feat_quant (combinational shift/offset/clamp, IN_W->BITS) is instantiated once.
//    It is reusable by other input stages.
// TESTING (N_FEAT=4, IN_W=8, BITS=2, SHIFT=4, OFFSET=2)
//  1. Clamp checks: s_data 0, -16, 16, -128, 127 -> codes 2, 1, 3, 0, 3.
//  2. Frame 0, -16, 16, -128 back-to-back with m_ready=1 -> m_data=8'h36.
//     m_valid is high exactly 1 cycle, the cycle after beat 4.
//  3. Backpressure: hold m_ready=0 for 5 cycles after FULL.
//     -> m_data stable at 8'h36, s_ready=0 throughout, no beat lost when the next frame starts.
//  4. Assert rst_n low after 2 accepted beats.
//     -> m_valid=0, err=0 immediately. The next 4 beats form a fresh frame with the correct packing.
//  5. FRAME_ERR_EN: s_last on beat 2 -> err=1 and no frame.
//     Then 4 beats with last on beat 4 -> frame emitted normally.
//  6. FRAME_ERR_EN: 6 beats with last only on beat 6 -> one frame from beats 1-4, err=1.
//     Beats 5-6 dropped, then COLLECT resumes.

Source files
------------

// File: rtl/logicnets_pkg.sv
// Shared types and helpers for the LogicNets input stages: FSM state encoding,
// counter sizing and the quantizer clamp bounds.
package logicnets_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        DROP    = 2'd2
    } lnq_state_t;

    localparam int LNQ_CODE_MIN = 0;

    function automatic int lnq_cnt_w(input int n_feat);
        return (n_feat < 2) ? 1 : $clog2(n_feat);
    endfunction

    function automatic int lnq_code_max(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/logicnets_feat_quant.sv
// Combinational feature quantizer: arithmetic shift, zero-point offset and clamp
// of a signed IN_W-bit value to an unsigned BITS-bit code.
module logicnets_feat_quant
    import logicnets_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int BITS   = 2,
    parameter int SHIFT  = 4,
    parameter int OFFSET = 2
) (
    input  logic [IN_W-1:0] din,
    output logic [BITS-1:0] code
);

    // One guard bit so the offset add cannot wrap for any input.
    localparam logic signed [IN_W:0] OFF  = (IN_W+1)'(OFFSET);
    localparam logic signed [IN_W:0] QMAX = (IN_W+1)'(lnq_code_max(BITS));
    localparam logic        [BITS-1:0] CODE_MIN = BITS'(LNQ_CODE_MIN);

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] q;

    always_comb begin
        ext = {din[IN_W-1], din};
        q   = (ext >>> SHIFT) + OFF;
        if (q[IN_W])
            code = CODE_MIN;
        else if (q > QMAX)
            code = QMAX[BITS-1:0];
        else
            code = q[BITS-1:0];
    end

endmodule

// File: rtl/logicnets_input_quantizer.sv
// Quantizes a stream of signed features and packs N_FEAT codes into one frame
// for the layer-0 neurons. Define LOGICNETS_FRAME_ERR_EN for s_last framing checks.
module logicnets_input_quantizer
    import logicnets_pkg::*;
#(
    parameter int N_FEAT = 4,
    parameter int IN_W   = 16,
    parameter int BITS   = 2,
    parameter int SHIFT  = 4,
    parameter int OFFSET = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [IN_W-1:0]        s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [N_FEAT*BITS-1:0] m_data
`ifdef LOGICNETS_FRAME_ERR_EN
    ,
    input  logic                   s_last,
    output logic                   err
`endif
);

    localparam int              CNT_W     = lnq_cnt_w(N_FEAT);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_FEAT - 1);

    lnq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [BITS-1:0]  code;
    logic             accept;
`ifdef LOGICNETS_FRAME_ERR_EN
    logic             drop_pend;
`endif

    logicnets_feat_quant #(
        .IN_W   (IN_W),
        .BITS   (BITS),
        .SHIFT  (SHIFT),
        .OFFSET (OFFSET)
    ) u_quant (
        .din  (s_data),
        .code (code)
    );

    assign s_ready = (state != FULL);
    assign m_valid = (state == FULL);
    assign accept  = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= COLLECT;
            cnt    <= '0;
            m_data <= '0;
`ifdef LOGICNETS_FRAME_ERR_EN
            err       <= 1'b0;
            drop_pend <= 1'b0;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < N_FEAT; i++) begin
                            if (cnt == CNT_W'(i))
                                m_data[i*BITS +: BITS] <= code;
                        end
                        if (cnt == LAST_SLOT) begin
                            cnt   <= '0;
                            state <= FULL;
`ifdef LOGICNETS_FRAME_ERR_EN
                            // Frame still goes out; the stray tail is flushed afterwards.
                            if (!s_last) begin
                                err       <= 1'b1;
                                drop_pend <= 1'b1;
                            end
`endif
                        end
`ifdef LOGICNETS_FRAME_ERR_EN
                        else if (s_last) begin
                            err <= 1'b1;
                            cnt <= '0;
                        end
`endif
                        else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (m_ready) begin
`ifdef LOGICNETS_FRAME_ERR_EN
                        if (drop_pend) begin
                            state     <= DROP;
                            drop_pend <= 1'b0;
                        end else
`endif
                        state <= COLLECT;
                    end
                end
                DROP: begin
`ifdef LOGICNETS_FRAME_ERR_EN
                    if (accept && s_last)
                        state <= COLLECT;
`else
                    state <= COLLECT;
`endif
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_logicnets_input_quantizer.sv
// Directed bench for logicnets_input_quantizer (N_FEAT=4, IN_W=8, BITS=2, SHIFT=4, OFFSET=2).
// Framing-error scenarios are included when LOGICNETS_FRAME_ERR_EN is defined.
module tb_logicnets_input_quantizer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = 8'h00;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       s_last = 1'b0;
    logic       err;

    int total = 0;
    int bad   = 0;

    logicnets_input_quantizer #(
        .N_FEAT (4),
        .IN_W   (8),
        .BITS   (2),
        .SHIFT  (4),
        .OFFSET (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
`ifdef LOGICNETS_FRAME_ERR_EN
        ,
        .s_last  (s_last),
        .err     (err)
`endif
    );

`ifndef LOGICNETS_FRAME_ERR_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    // Presents one beat (called #1 after a rising edge) and returns #1 after the edge that accepts it.
    task automatic beat(input logic [7:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        n = 0;
        while (!s_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (!s_ready) begin
            bad++;
            $display("FAIL beat_timeout: s_ready=%0b required 1 within 50 cycles", s_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
        total++;
        if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0b want 0", err); end
    endtask

    // Codes: 127->3, -128->0, -16->1, 0->2, packed 8'h93; then -17->0, 15->2, -1->1, 47->3 packed 8'hD8.
    task automatic test_clamp();
        m_ready = 1'b1;
        beat(8'h7F, 1'b0);
        beat(8'h80, 1'b0);
        beat(8'hF0, 1'b0);
        beat(8'h00, 1'b1);
        idle();
        total++;
        if (m_valid !== 1'b1) begin bad++; $display("FAIL clamp_a_valid: got %0b want 1", m_valid); end
        total++;
        if (m_data[1:0] !== 2'd3) begin bad++; $display("FAIL clamp_127: got %0d want 3", m_data[1:0]); end
        total++;
        if (m_data[3:2] !== 2'd0) begin bad++; $display("FAIL clamp_m128: got %0d want 0", m_data[3:2]); end
        total++;
        if (m_data[5:4] !== 2'd1) begin bad++; $display("FAIL clamp_m16: got %0d want 1", m_data[5:4]); end
        total++;
        if (m_data[7:6] !== 2'd2) begin bad++; $display("FAIL clamp_0: got %0d want 2", m_data[7:6]); end
        @(posedge clk); #1;
        beat(8'hEF, 1'b0);
        beat(8'h0F, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'h2F, 1'b1);
        idle();
        total++;
        if (m_valid !== 1'b1) begin bad++; $display("FAIL clamp_b_valid: got %0b want 1", m_valid); end
        total++;
        if (m_data !== 8'hD8) begin bad++; $display("FAIL clamp_b_data: got %h want d8", m_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        beat(8'h00, 1'b0);
        beat(8'hF0, 1'b0);
        beat(8'h10, 1'b0);
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid: got %0b want 0", m_valid); end
        beat(8'h80, 1'b1);
        idle();
        total++;
        if (m_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %0b want 1", m_valid); end
        total++;
        if (m_data !== 8'h36) begin bad++; $display("FAIL b2b_data: got %h want 36", m_data); end
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL b2b_s_ready_full: got %0b want 0", s_ready); end
        @(posedge clk); #1;
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop: got %0b want 0", m_valid); end
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL b2b_s_ready_back: got %0b want 1", s_ready); end
    endtask

    task automatic test_backpressure();
        m_ready = 1'b0;
        beat(8'h00, 1'b0);
        beat(8'hF0, 1'b0);
        beat(8'h10, 1'b0);
        beat(8'h80, 1'b1);
        // Next frame's first beat waits on the bus while the frame is held.
        s_valid = 1'b1;
        s_data  = 8'h7F;
        s_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== 8'h36 || s_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold_%0d: m_valid=%0b m_data=%h s_ready=%0b want 1 36 0",
                         c, m_valid, m_data, s_ready);
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %0b want 0", m_valid); end
        beat(8'h7F, 1'b0);
        beat(8'h80, 1'b0);
        beat(8'hF0, 1'b0);
        beat(8'h00, 1'b1);
        idle();
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'h93) begin
            bad++;
            $display("FAIL bp_next_frame: m_valid=%0b m_data=%h want 1 93", m_valid, m_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        m_ready = 1'b1;
        beat(8'h7F, 1'b0);
        beat(8'h7F, 1'b0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (m_valid !== 1'b0 || err !== 1'b0 || m_data !== 8'h00 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_outputs: m_valid=%0b err=%0b m_data=%h s_ready=%0b want 0 0 00 1",
                     m_valid, err, m_data, s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(8'hEF, 1'b0);
        beat(8'h0F, 1'b0);
        beat(8'hFF, 1'b0);
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_early_valid: got %0b want 0", m_valid); end
        beat(8'h2F, 1'b1);
        idle();
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'hD8) begin
            bad++;
            $display("FAIL midrst_frame: m_valid=%0b m_data=%h want 1 d8", m_valid, m_data);
        end
        @(posedge clk); #1;
    endtask

`ifdef LOGICNETS_FRAME_ERR_EN
    task automatic test_early_last();
        do_reset();
        m_ready = 1'b1;
        beat(8'h00, 1'b0);
        beat(8'h10, 1'b1);
        idle();
        total++;
        if (err !== 1'b1 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL early_last_err: err=%0b m_valid=%0b want 1 0", err, m_valid);
        end
        @(posedge clk); #1;
        beat(8'h00, 1'b0);
        beat(8'hF0, 1'b0);
        beat(8'h10, 1'b0);
        beat(8'h80, 1'b1);
        idle();
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'h36 || err !== 1'b1) begin
            bad++;
            $display("FAIL early_last_frame: m_valid=%0b m_data=%h err=%0b want 1 36 1", m_valid, m_data, err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_missing_last();
        do_reset();
        m_ready = 1'b1;
        beat(8'h00, 1'b0);
        beat(8'hF0, 1'b0);
        beat(8'h10, 1'b0);
        beat(8'h80, 1'b0);
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'h36 || err !== 1'b1) begin
            bad++;
            $display("FAIL miss_last_frame: m_valid=%0b m_data=%h err=%0b want 1 36 1", m_valid, m_data, err);
        end
        beat(8'h7F, 1'b0);
        beat(8'h7F, 1'b1);
        idle();
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL miss_last_drop: m_valid=%0b want 0", m_valid); end
        beat(8'hEF, 1'b0);
        beat(8'h0F, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'h2F, 1'b1);
        idle();
        total++;
        if (m_valid !== 1'b1 || m_data !== 8'hD8) begin
            bad++;
            $display("FAIL miss_last_resume: m_valid=%0b m_data=%h want 1 d8", m_valid, m_data);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_clamp();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_frame();
`ifdef LOGICNETS_FRAME_ERR_EN
        test_early_last();
        test_missing_last();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
